stft_framer: RTL

Streaming front end of the posit STFT datapath. Collects a serial stream of 32-bit real samples into 4-sample frames and presents each frame, in parallel and registered, to the 4-point FFT stage. Imaginary inputs are tied to zero. It provides input backpressure and a held output frame with a valid/ready handshake, so the combinational FFT core always sees stable operands.

---
 rtl/stft_framer_if.sv | 35 +++
 rtl/stft_framer.sv | 109 ++++++++++
 2 files changed

// File: rtl/stft_framer_if.sv
// Handshake bundle for stft_framer: sample stream in, parallel frame out.
// master drives samples and frame_ready; slave is the framer.
interface stft_framer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              frame_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] re_x0;
  logic [DATA_W-1:0] re_x1;
  logic [DATA_W-1:0] re_x2;
  logic [DATA_W-1:0] re_x3;
  logic [DATA_W-1:0] im_x0;
  logic [DATA_W-1:0] im_x1;
  logic [DATA_W-1:0] im_x2;
  logic [DATA_W-1:0] im_x3;
  logic [CNT_W-1:0]  frame_idx;

  modport master (
    output in_valid, in_data, frame_ready,
    input  in_ready, frame_valid, frame_idx,
    input  re_x0, re_x1, re_x2, re_x3,
    input  im_x0, im_x1, im_x2, im_x3
  );

  modport slave (
    input  in_valid, in_data, frame_ready,
    output in_ready, frame_valid, frame_idx,
    output re_x0, re_x1, re_x2, re_x3,
    output im_x0, im_x1, im_x2, im_x3
  );
endinterface

// File: rtl/stft_framer.sv
// STFT framer: serial samples -> held 4-sample frames with valid/ready.
// STFT_FRAMER_OVERLAP_EN selects hop 2 (50% overlap); default hop 4.
module stft_framer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  stft_framer_if.slave bus
);

`ifdef STFT_FRAMER_OVERLAP_EN
  localparam logic [1:0] HOP_LAST = 2'd1;
`else
  localparam logic [1:0] HOP_LAST = 2'd3;
`endif

  typedef enum logic {FILL, HOP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q [4];
  logic [DATA_W-1:0] sr_d [4];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic              fv_q, fv_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic completing;
  logic ready;
  logic accept;
  logic xfer;
  logic load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    out_d   = out_q;
    fv_d    = fv_q;
    idx_d   = idx_q;

    completing = (state_q == FILL) ? (cnt_q == 2'd3)
                                   : (cnt_q == HOP_LAST);
    // only a completing sample needs the output slot
    ready  = !(completing && fv_q && !bus.frame_ready);
    accept = bus.in_valid && ready;
    xfer   = fv_q && bus.frame_ready;
    load   = accept && completing;

    if (accept) begin
      sr_d[0] = sr_q[1];
      sr_d[1] = sr_q[2];
      sr_d[2] = sr_q[3];
      sr_d[3] = bus.in_data;
      if (completing) begin
        cnt_d   = 2'd0;
        state_d = HOP;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end

    if (load) begin
      out_d[0] = sr_q[1];
      out_d[1] = sr_q[2];
      out_d[2] = sr_q[3];
      out_d[3] = bus.in_data;
    end

    fv_d = load || (fv_q && !xfer);
    if (xfer) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
      fv_q    <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        sr_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 4; i++) begin
        sr_q[i]  <= sr_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.frame_valid = fv_q;
  assign bus.frame_idx   = idx_q;
  assign bus.re_x0       = out_q[0];
  assign bus.re_x1       = out_q[1];
  assign bus.re_x2       = out_q[2];
  assign bus.re_x3       = out_q[3];
  assign bus.im_x0       = '0;
  assign bus.im_x1       = '0;
  assign bus.im_x2       = '0;
  assign bus.im_x3       = '0;

endmodule
